// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop walk two
// WIDTH-bit operands LSB-first, with a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             s_bit, c_next;

  always_comb begin
    s_bit   = a_q[0] ^ b_q[0] ^ c_q;
    c_next  = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtract runs as a + ~b + ~borrow, so invert B and the incoming carry.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = cin ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {s_bit, r_q[WIDTH-1:1]};
        c_d   = c_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // c_q here is the carry into the MSB, c_next the carry out of it.
          cnt_d   = cnt_q;
          sum_d   = {s_bit, r_q[WIDTH-1:1]};
          cout_d  = c_next;
          ovf_d   = c_q ^ c_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed WIDTH=8 scenarios plus WIDTH=4/2/32 sweeps
// against an integer-arithmetic model.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // WIDTH=8 instance for directed tests
  logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  // Sweep instances share operand inputs; index 0:W4, 1:W2, 2:W32
  logic [31:0] ax, bx;
  logic        subx, cinx;
  logic [2:0]  startv, busyv, donev, coutv, ovfv;
  logic [3:0]  sum4;
  logic [1:0]  sum2;
  logic [31:0] sum32;

  serial_addsub #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(startv[0]), .sub(subx), .a(ax[3:0]), .b(bx[3:0]), .cin(cinx),
    .busy(busyv[0]), .done(donev[0]), .sum(sum4), .cout(coutv[0]), .ovf(ovfv[0]));
  serial_addsub #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(startv[1]), .sub(subx), .a(ax[1:0]), .b(bx[1:0]), .cin(cinx),
    .busy(busyv[1]), .done(donev[1]), .sum(sum2), .cout(coutv[1]), .ovf(ovfv[1]));
  serial_addsub #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(startv[2]), .sub(subx), .a(ax), .b(bx), .cin(cinx),
    .busy(busyv[2]), .done(donev[2]), .sum(sum32), .cout(coutv[2]), .ovf(ovfv[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned and signed integer arithmetic, no bit-level carry chain.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic s, input logic c,
                                output logic [31:0] rs, output logic rco, output logic rov);
    longint m, ua, ub, sa, sb, ci, t, r;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    ci = c ? 1 : 0;
    if (!s) begin
      t   = ua + ub + ci;
      rco = (t >= m);
      r   = sa + sb + ci;
    end else begin
      t   = ua - ub - ci;
      rco = (t >= 0);
      r   = sa - sb - ci;
    end
    rs  = 32'(t & (m - 1));
    rov = (r < -(m / 2)) || (r >= m / 2);
  endfunction

  typedef struct {logic [7:0] s; logic co; logic ov;} res_t;
  res_t exp_q[$];
  res_t e_cur;
  logic [7:0] h_s;
  logic       h_c, h_o;

  task automatic push_exp(input logic [7:0] s, input logic co, input logic ov);
    res_t r;
    r.s = s; r.co = co; r.ov = ov;
    exp_q.push_back(r);
  endtask

  // Compare process for the WIDTH=8 instance: every done must match the next
  // expected result, outputs must hold between dones, busy/done exclusive.
  initial begin
    h_s = '0; h_c = 1'b0; h_o = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h_s = '0; h_c = 1'b0; h_o = 1'b0;
      end else begin
        chk("busy_done_excl", {63'd0, busy8 & done8}, 64'd0);
        if (done8) begin
          if (exp_q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
          else begin
            e_cur = exp_q.pop_front();
            chk("sum8", {56'd0, sum8}, {56'd0, e_cur.s});
            chk("cout8", {63'd0, cout8}, {63'd0, e_cur.co});
            chk("ovf8", {63'd0, ovf8}, {63'd0, e_cur.ov});
            h_s = e_cur.s; h_c = e_cur.co; h_o = e_cur.ov;
          end
        end else begin
          chk("hold8", {54'd0, sum8, cout8, ovf8}, {54'd0, h_s, h_c, h_o});
        end
      end
    end
  end

  // One WIDTH=8 op with literal expectations; also pins the model and timing.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                     input logic [7:0] es, input logic eco, input logic eov);
    logic [31:0] ms;
    logic        mco, mov;
    int          nb;
    model(8, {24'd0, a}, {24'd0, b}, s, c, ms, mco, mov);
    chk("model_pin", {31'd0, ms, mco, mov}, {31'd0, 24'd0, es, eco, eov});
    @(posedge clk); #1;
    a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
    push_exp(es, eco, eov);
    @(posedge clk); #1;
    start8 = 1'b0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8) nb++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", 64'(nb), 64'd8);
    chk("done_at_k+W", {62'd0, done8, busy8}, {62'd0, 2'b10});
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, done8}, 64'd0);
  endtask

  task automatic wait_done8(input int n);
    bit got = 1'b0;
    for (int i = 0; i < n && !got; i++) begin
      @(posedge clk); #1;
      if (done8) got = 1'b1;
    end
    chk("done8_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic opx(input int sel, input int w, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic c);
    logic [31:0] es, as;
    logic        eco, eov;
    bit          got;
    model(w, a, b, s, c, es, eco, eov);
    @(posedge clk); #1;
    ax = a; bx = b; subx = s; cinx = c; startv[sel] = 1'b1;
    @(posedge clk); #1;
    startv = '0;
    chk($sformatf("busy_w%0d", w), {63'd0, busyv[sel]}, 64'd1);
    got = 1'b0;
    for (int i = 0; i < w + 4 && !got; i++) begin
      if (donev[sel]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk($sformatf("done_timeout_w%0d", w), {63'd0, got}, 64'd1);
    if (got) begin
      case (sel)
        0:       as = {28'd0, sum4};
        1:       as = {30'd0, sum2};
        default: as = sum32;
      endcase
      chk($sformatf("sum_w%0d a=%0h b=%0h s=%0d c=%0d", w, a, b, s, c), {32'd0, as}, {32'd0, es});
      chk($sformatf("cout_w%0d", w), {63'd0, coutv[sel]}, {63'd0, eco});
      chk($sformatf("ovf_w%0d", w), {63'd0, ovfv[sel]}, {63'd0, eov});
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; cin8 = 1'b1;
    startv = '0; ax = '0; bx = '0; subx = 1'b0; cinx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy8}, 64'd0);
    chk("rst_done", {63'd0, done8}, 64'd0);
    chk("rst_sum", {56'd0, sum8}, 64'd0);
    chk("rst_cout", {63'd0, cout8}, 64'd0);
    chk("rst_ovf", {63'd0, ovf8}, 64'd0);
    rst = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    chk("start_in_rst_ignored", {63'd0, busy8}, 64'd0);

    op8(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    op8(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

    // Start and operand changes mid-run must be ignored.
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    push_exp(8'h03, 1'b0, 1'b0);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(12);
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_sum", {56'd0, sum8}, 64'h03);

    // Reset at bit 4 aborts and clears outputs without a clock edge.
    a8 = 8'h55; b8 = 8'h11; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_sum", {56'd0, sum8}, 64'd0);
    chk("arst_flags", {60'd0, busy8, done8, cout8, ovf8}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    // Back-to-back with start held through the done cycle.
    @(posedge clk); #1;
    a8 = 8'h20; b8 = 8'h03; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    push_exp(8'h23, 1'b0, 1'b0);
    push_exp(8'h20, 1'b1, 1'b1);
    @(posedge clk); #1;
    a8 = 8'h90; b8 = 8'h90;
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("b2b_done_%0d", j), {63'd0, done8}, {63'd0, (j == 8 || j == 17)});
      if (j == 9) start8 = 1'b0;
      @(posedge clk); #1;
    end
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++)
          for (int c = 0; c < 2; c++)
            opx(0, 4, 32'(a), 32'(b), s[0], c[0]);
    for (int i = 0; i < 1000; i++)
      opx(1, 2, $urandom & 32'h3, $urandom & 32'h3, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++)
      opx(2, 32, $urandom, $urandom, 1'($urandom), 1'($urandom));

    chk("exp_q_final", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
